game_timer_ctrl: RTL

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_pkg.sv | 18 +
 rtl/game_timer_ctrl_if.sv | 31 +++
 rtl/game_timer_ctrl_tick_gen.sv | 42 ++++
 rtl/game_timer_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
`default_nettype none
// ============================================================
// game_timer_pkg : shared state encoding and tick default
// Rev 1.0
// ============================================================
package game_timer_pkg;

   localparam logic [31:0] CYCLES_PER_TICK_DEFAULT = 32'd50_000_000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } timer_state_e;

endpackage : game_timer_pkg
`default_nettype wire

// File: rtl/game_timer_ctrl_if.sv
`default_nettype none
// ============================================================
// game_timer_ctrl_if : control/status bundle of the game timer
// Rev 1.0
// ============================================================
interface game_timer_ctrl_if (
   input wire logic iclk
);
   logic       istart;
   logic [7:0] iload_sec;
   logic       ipause;
   logic       iclear;
   logic [7:0] osec;
   logic       otick;
   logic       obusy;
   logic       oexpired;
   logic       odone;

   modport master (
      input  iclk,
      output istart, iload_sec, ipause, iclear,
      input  osec, otick, obusy, oexpired, odone
   );

   modport slave (
      input  iclk,
      input  istart, iload_sec, ipause, iclear,
      output osec, otick, obusy, oexpired, odone
   );
endinterface : game_timer_ctrl_if
`default_nettype wire

// File: rtl/game_timer_ctrl_tick_gen.sv
`default_nettype none
// ============================================================
// tick_gen : one-second prescaler; flags its terminal count
// Rev 1.0
// ============================================================
module tick_gen
   import game_timer_pkg::*;
#(
   parameter logic [31:0] CYCLES_PER_TICK = CYCLES_PER_TICK_DEFAULT
) (
   input  wire logic iclk,
   input  wire logic irst_n,
   input  wire logic ien,
   input  wire logic iclr,
   output logic      otick_raw
);
   localparam logic [31:0] LAST_COUNT = CYCLES_PER_TICK - 32'd1;

   logic [31:0] count_q;
   logic [31:0] count_d;

   // Terminal flag is not gated by ien: the controller decides whether it counts.
   assign otick_raw = (count_q == LAST_COUNT);

   always_comb begin
      count_d = count_q;
      if (iclr) begin
         count_d = 32'd0;
      end else if (ien) begin
         count_d = otick_raw ? 32'd0 : count_q + 32'd1;
      end
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         count_q <= 32'd0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule : tick_gen
`default_nettype wire

// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================
// game_timer_ctrl : countdown timer FSM with pause/clear, registered outputs
// Rev 1.0
// ============================================================
module game_timer_ctrl
   import game_timer_pkg::*;
#(
   parameter logic [31:0] CYCLES_PER_TICK = CYCLES_PER_TICK_DEFAULT
) (
   input  wire logic       iclk,
   input  wire logic       irst_n,
   input  wire logic       istart,
   input  wire logic [7:0] iload_sec,
   input  wire logic       ipause,
   input  wire logic       iclear,
   output logic [7:0]      osec,
   output logic            otick,
   output logic            obusy,
   output logic            oexpired,
   output logic            odone
);
   timer_state_e state_q, state_d;
   logic [7:0]   sec_q, sec_d;
   logic         tick_q, tick_d;
   logic         done_q, done_d;
   logic         busy_q, busy_d;
   logic         expired_q, expired_d;
   logic         presc_en;
   logic         presc_clr;
   logic         presc_last;

   tick_gen #(
      .CYCLES_PER_TICK (CYCLES_PER_TICK)
   ) u_tick_gen (
      .iclk      (iclk),
      .irst_n    (irst_n),
      .ien       (presc_en),
      .iclr      (presc_clr),
      .otick_raw (presc_last)
   );

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      tick_d    = 1'b0;
      done_d    = 1'b0;
      presc_en  = 1'b0;
      presc_clr = 1'b0;

      if (iclear) begin
         state_d   = IDLE;
         sec_d     = 8'd0;
         presc_clr = 1'b1;
      end else if (istart) begin
         presc_clr = 1'b1;
         if (iload_sec != 8'd0) begin
            state_d = RUN;
            sec_d   = iload_sec;
         end else begin
            state_d = EXPIRED;
            sec_d   = 8'd0;
            done_d  = 1'b1;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (ipause) begin
                  state_d = PAUSE;
               end else begin
                  presc_en = 1'b1;
                  if (presc_last) begin
                     tick_d = 1'b1;
                     // Guard against underflow even if RUN were reached with 0.
                     if (sec_q <= 8'd1) begin
                        sec_d   = 8'd0;
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                     end else begin
                        sec_d = sec_q - 8'd1;
                     end
                  end
               end
            end
            PAUSE: begin
               if (!ipause) begin
                  state_d = RUN;
               end
            end
            EXPIRED: begin
               sec_d = 8'd0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d    = (state_d == RUN) || (state_d == PAUSE);
      expired_d = (state_d == EXPIRED);
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         state_q   <= IDLE;
         sec_q     <= 8'd0;
         tick_q    <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sec_q     <= sec_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         expired_q <= expired_d;
      end
   end

   assign osec     = sec_q;
   assign otick    = tick_q;
   assign obusy    = busy_q;
   assign oexpired = expired_q;
   assign odone    = done_q;
endmodule : game_timer_ctrl
`default_nettype wire
